// File: rtl/audio_dac_serializer.sv
// Purpose : I2S stereo DAC serializer; generates AUD_BCLK/AUD_DACLRCK from AUDIO_CLK and shifts 16-bit L/R samples out MSB first.
// Latency : accepted sample's left MSB reaches AUD_DACDAT one AUD_BCLK period after the next frame boundary.
// Backpr. : single holding register; sample_ready drops while it is full and rises again when a frame boundary drains it.
//
// Ports:
//   AUDIO_CLK     in   system audio clock, rising edge
//   rst           in   asynchronous active-low reset
//   sample_in     in   [31:16] left, [15:0] right, two's complement
//   sample_valid  in   sample_in valid this cycle
//   sample_ready  out  holding register empty (combinational)
//   AUD_BCLK      out  bit clock, BCLK_DIV AUDIO_CLK cycles per half period
//   AUD_DACLRCK   out  word clock, 0 = left slot, 1 = right slot
//   AUD_DACDAT    out  serial data, one BCLK delayed after each LRCK edge
//   frame_start   out  one-cycle pulse at each frame boundary
//   underrun      out  one-cycle pulse when a boundary found no new sample
module audio_dac_serializer #(
    parameter int BCLK_DIV  = 4,
    parameter int SLOT_BITS = 32
) (
    input  logic        AUDIO_CLK,
    input  logic        rst,
    input  logic [31:0] sample_in,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        AUD_BCLK,
    output logic        AUD_DACLRCK,
    output logic        AUD_DACDAT,
    output logic        frame_start,
    output logic        underrun
);

    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int BIT_W = $clog2(2 * SLOT_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(2 * SLOT_BITS - 1);
    localparam logic [BIT_W-1:0] SLOT_SIZE = BIT_W'(SLOT_BITS);

    logic [DIV_W-1:0] r_div;
    logic             r_bclk;
    logic [BIT_W-1:0] r_bit_cnt;
    logic             r_lrck;
    logic             r_dat;
    logic [31:0]      r_shadow;
    logic [31:0]      r_hold;
    logic             r_hold_full;
    logic             r_frame_start;
    logic             r_underrun;

    logic             w_div_tc;
    logic             w_fall;
    logic             w_bit_last;
    logic             w_boundary;
    logic             w_accept;
    logic [BIT_W-1:0] w_bit_nxt;
    logic             w_lrck_nxt;
    logic [BIT_W-1:0] w_pos_nxt;
    logic [15:0]      w_chan;
    logic [3:0]       w_bit_idx;
    logic             w_dat_nxt;

    assign w_div_tc   = (r_div == DIV_LAST);
    assign w_fall     = w_div_tc & r_bclk;
    assign w_bit_last = (r_bit_cnt == BIT_LAST);
    assign w_boundary = w_fall & w_bit_last;
    assign w_accept   = sample_valid & ~r_hold_full;

    // Serial outputs are registered from the post-fall bit position so that
    // LRCK and DAT change together on the BCLK falling edge.
    assign w_bit_nxt  = w_bit_last ? '0 : r_bit_cnt + 1'b1;
    assign w_lrck_nxt = (w_bit_nxt >= SLOT_SIZE);
    assign w_pos_nxt  = w_lrck_nxt ? (w_bit_nxt - SLOT_SIZE) : w_bit_nxt;
    assign w_chan     = w_lrck_nxt ? r_shadow[15:0] : r_shadow[31:16];
    assign w_bit_idx  = 4'(5'd16 - 5'(w_pos_nxt));

    // Position 0 of each slot is the I2S delay bit and positions past 16 pad
    // the slot. Because a boundary always lands on position 0, reading the
    // old shadow here is safe even on the cycle the shadow reloads.
    assign w_dat_nxt  = (w_pos_nxt >= BIT_W'(1)) && (w_pos_nxt <= BIT_W'(16))
                        ? w_chan[w_bit_idx] : 1'b0;

    always_ff @(posedge AUDIO_CLK or negedge rst) begin
        if (!rst) begin
            r_div  <= '0;
            r_bclk <= 1'b0;
        end else if (w_div_tc) begin
            r_div  <= '0;
            r_bclk <= ~r_bclk;
        end else begin
            r_div  <= r_div + 1'b1;
        end
    end

    always_ff @(posedge AUDIO_CLK or negedge rst) begin
        if (!rst) begin
            r_bit_cnt <= '0;
            r_lrck    <= 1'b0;
            r_dat     <= 1'b0;
        end else if (w_fall) begin
            r_bit_cnt <= w_bit_nxt;
            r_lrck    <= w_lrck_nxt;
            r_dat     <= w_dat_nxt;
        end
    end

    // An accept can never coincide with a drain: accept needs an empty
    // holding register and a drain needs a full one.
    always_ff @(posedge AUDIO_CLK or negedge rst) begin
        if (!rst) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_shadow    <= '0;
        end else begin
            if (w_accept) begin
                r_hold      <= sample_in;
                r_hold_full <= 1'b1;
            end else if (w_boundary && r_hold_full) begin
                r_hold_full <= 1'b0;
            end
            if (w_boundary && r_hold_full) begin
                r_shadow <= r_hold;
            end
        end
    end

    always_ff @(posedge AUDIO_CLK or negedge rst) begin
        if (!rst) begin
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_frame_start <= w_boundary;
            r_underrun    <= w_boundary & ~r_hold_full;
        end
    end

    assign sample_ready = ~r_hold_full;
    assign AUD_BCLK     = r_bclk;
    assign AUD_DACLRCK  = r_lrck;
    assign AUD_DACDAT   = r_dat;
    assign frame_start  = r_frame_start;
    assign underrun     = r_underrun;

endmodule
